// File: rtl/cnn1d_pkg.sv
// Shared types and helpers for the 1D CNN pooling path.
package cnn1d_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } accum_sched_state_t;

  // Ceiling log2, with clog2(1) = 0.
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 32'sd0;
    rem = value - 32'sd1;
    while (rem > 32'sd0) begin
      res = res + 32'sd1;
      rem = rem >>> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/accum_scheduler_rr_arbiter.sv
// Combinational channel arbiter for accum_scheduler.
// ACCUM_SCHED_FIXED_PRIO_EN selects lowest-index-wins instead of round-robin.
module rr_arbiter
  import cnn1d_pkg::*;
#(
  parameter int  NUM_CHANNELS = 4,
  localparam int CH_W = (NUM_CHANNELS > 1) ? clog2(NUM_CHANNELS) : 1
) (
  input  logic [NUM_CHANNELS-1:0] req,
  input  logic [CH_W-1:0]         last,
  output logic [CH_W-1:0]         winner,
  output logic                    any
);

  assign any = |req;

`ifdef ACCUM_SCHED_FIXED_PRIO_EN
  logic unused_last_s;
  assign unused_last_s = ^last;

  // Scan downwards so the lowest requesting index is written last.
  always_comb begin
    winner = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner = CH_W'(i);
      end else begin
        winner = winner;
      end
    end
  end
`else
  int idx_s;

  // Walk the search order backwards so the first candidate after last wins.
  always_comb begin
    winner = '0;
    idx_s  = 0;
    for (int k = NUM_CHANNELS; k >= 1; k--) begin
      idx_s = (int'(last) + k) % NUM_CHANNELS;
      if (req[idx_s]) begin
        winner = CH_W'(idx_s);
      end else begin
        winner = winner;
      end
    end
  end
`endif

endmodule

// File: rtl/accum_scheduler.sv
// Shares one pooling accumulator between NUM_CHANNELS streams, one POOL_SIZE window per grant.
// Optional macro ACCUM_SCHED_FIXED_PRIO_EN switches the arbiter to fixed priority.
module accum_scheduler
  import cnn1d_pkg::*;
#(
  parameter int  NUM_CHANNELS = 4,
  parameter int  DATA_WIDTH   = 12,
  parameter int  POOL_SIZE    = 10,
  localparam int CNT_W = clog2(POOL_SIZE),
  localparam int ACC_W = DATA_WIDTH + CNT_W,
  localparam int CH_W  = (NUM_CHANNELS > 1) ? clog2(NUM_CHANNELS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CHANNELS-1:0]          sched_valid_in,
  output logic [NUM_CHANNELS-1:0]          sched_ready_in,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] sched_data_in,
  input  logic                             sched_ready_out,
  output logic                             sched_valid_out,
  output logic [ACC_W-1:0]                 sched_data_out,
  output logic [CH_W-1:0]                  sched_chan_out,
  output logic                             sched_busy
);

  // Counter keeps at least one bit so POOL_SIZE=1 still elaborates.
  localparam int                 CNT_RW   = (CNT_W > 0) ? CNT_W : 1;
  localparam logic [CNT_RW-1:0]  LAST_CNT = CNT_RW'(POOL_SIZE - 1);
  localparam logic [CNT_RW-1:0]  CNT_ONE  = CNT_RW'(1);
  localparam logic [CH_W-1:0]    LAST_RST = CH_W'(NUM_CHANNELS - 1);

  accum_sched_state_t        state_r, state_nx_s;
  logic [CH_W-1:0]           grant_r, last_r, arb_winner_s;
  logic                      arb_any_s;
  logic [ACC_W-1:0]          acc_r, sum_s;
  logic [CNT_RW-1:0]         count_r;
  logic [DATA_WIDTH-1:0]     sample_s;
  logic                      in_hs_s, last_beat_s;
  logic                      valid_out_r;
  logic [ACC_W-1:0]          data_out_r;
  logic [CH_W-1:0]           chan_out_r;
  logic [NUM_CHANNELS-1:0]   ready_s;

  rr_arbiter #(
    .NUM_CHANNELS(NUM_CHANNELS)
  ) u_arb (
    .req    (sched_valid_in),
    .last   (last_r),
    .winner (arb_winner_s),
    .any    (arb_any_s)
  );

  assign sample_s    = sched_data_in[int'(grant_r) * DATA_WIDTH +: DATA_WIDTH];
  assign sum_s       = acc_r + ACC_W'(sample_s);
  assign in_hs_s     = (state_r == ACCUM) && sched_valid_in[grant_r];
  assign last_beat_s = (count_r == LAST_CNT);

  assign sched_ready_in  = ready_s;
  assign sched_valid_out = valid_out_r;
  assign sched_data_out  = data_out_r;
  assign sched_chan_out  = chan_out_r;
  assign sched_busy      = (state_r != IDLE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and ready decode.
  always_comb begin
    state_nx_s = state_r;
    ready_s    = '0;
    case (state_r)
      IDLE: begin
        if (arb_any_s) begin
          state_nx_s = ACCUM;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ACCUM: begin
        ready_s[grant_r] = 1'b1;
        if (in_hs_s && last_beat_s) begin
          state_nx_s = OUTPUT;
        end else begin
          state_nx_s = ACCUM;
        end
      end
      OUTPUT: begin
        if (sched_ready_out) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = OUTPUT;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Grant, accumulator, counter and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r     <= '0;
      last_r      <= LAST_RST;
      acc_r       <= '0;
      count_r     <= '0;
      valid_out_r <= 1'b0;
      data_out_r  <= '0;
      chan_out_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (arb_any_s) begin
            grant_r <= arb_winner_s;
          end
        end
        ACCUM: begin
          if (in_hs_s && last_beat_s) begin
            data_out_r  <= sum_s;
            chan_out_r  <= grant_r;
            valid_out_r <= 1'b1;
            acc_r       <= '0;
            count_r     <= '0;
          end else if (in_hs_s) begin
            acc_r   <= sum_s;
            count_r <= count_r + CNT_ONE;
          end
        end
        OUTPUT: begin
          if (sched_ready_out) begin
            valid_out_r <= 1'b0;
            last_r      <= grant_r;
          end
        end
        default: begin
          valid_out_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
